// File: rtl/systolic_feeder_if.sv
// Beat/edge bundle between the systolic feeder and its neighbours.
// master drives beats into the feeder; slave is the feeder itself.
interface systolic_feeder_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 32
);
  logic           in_valid;
  logic           in_ready;
  logic           in_last;
  logic [N*W-1:0] in_a;
  logic [N*W-1:0] in_b;
  logic [N*W-1:0] west_data;
  logic [N*W-1:0] north_data;
  logic           busy;
  logic           done;

  modport master (
    output in_valid, in_last, in_a, in_b,
    input  in_ready, west_data, north_data, busy, done
  );

  modport slave (
    input  in_valid, in_last, in_a, in_b,
    output in_ready, west_data, north_data, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Diagonal skew feeder for the west/north edges of an NxN MAC grid.
// Optional FEEDER_BEAT_CNT_EN adds a saturating per-operation beat_count port.
module systolic_feeder #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned DRAIN = 12
) (
  input  logic               clk,
  input  logic               rst,
  systolic_feeder_if.slave   bus
`ifdef FEEDER_BEAT_CNT_EN
  ,
  output logic [15:0]        beat_count
`endif
);

  localparam int unsigned FLUSH_LEN = N - 1 + DRAIN;
  localparam int unsigned CNT_W     = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             ready_r;
  logic             busy_r;
  logic             done_r;
  logic             ready_d;
  logic             busy_d;
  logic             done_d;
  logic             accept;

  assign accept = bus.in_valid && ready_r;

  // State register; status outputs are registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      ready_r <= ready_d;
      busy_r  <= busy_d;
      done_r  <= done_d;
    end
  end

  // Next-state and drain counter.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE, ST_STREAM: begin
        if (accept) begin
          if (bus.in_last) begin
            state_next = ST_FLUSH;
            cnt_next   = CNT_LOAD;
          end else begin
            state_next = ST_STREAM;
          end
        end
      end
      ST_FLUSH: begin
        if (cnt == '0) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode of the state being entered.
  always_comb begin
    ready_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_next)
      ST_IDLE:   ready_d = 1'b1;
      ST_STREAM: begin
        ready_d = 1'b1;
        busy_d  = 1'b1;
      end
      ST_FLUSH:  busy_d = 1'b1;
      ST_DONE:   done_d = 1'b1;
      default:   ready_d = 1'b0;
    endcase
  end

  assign bus.in_ready = ready_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

  // Lane i gets an (i+1)-deep shift chain; non-accepted cycles inject zeros.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [W-1:0]       head_a;
    logic [W-1:0]       head_b;
    logic [(i+1)*W-1:0] sr_a;
    logic [(i+1)*W-1:0] sr_b;

    assign head_a = accept ? bus.in_a[i*W +: W] : '0;
    assign head_b = accept ? bus.in_b[i*W +: W] : '0;

    if (i == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (rst) begin
          sr_a <= '0;
          sr_b <= '0;
        end else begin
          sr_a <= head_a;
          sr_b <= head_b;
        end
      end
    end else begin : g_shift
      always_ff @(posedge clk) begin
        if (rst) begin
          sr_a <= '0;
          sr_b <= '0;
        end else begin
          sr_a <= {sr_a[i*W-1:0], head_a};
          sr_b <= {sr_b[i*W-1:0], head_b};
        end
      end
    end

    assign bus.west_data[i*W +: W]  = sr_a[i*W +: W];
    assign bus.north_data[i*W +: W] = sr_b[i*W +: W];
  end

`ifdef FEEDER_BEAT_CNT_EN
  // First beat out of IDLE restarts the count; later beats saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_count <= '0;
    end else if (accept) begin
      if (state == ST_IDLE) begin
        beat_count <= 16'd1;
      end else if (beat_count != 16'hFFFF) begin
        beat_count <= beat_count + 16'd1;
      end
    end
  end
`endif

endmodule
